// File: rtl/reg_spill_pkg.sv
// Shared definitions for the register spill/fill engine: FSM encoding,
// register-file geometry and index width.
package reg_spill_pkg;

  localparam int NREGS = 16;
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    RD   = 3'd2,
    MEM  = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/reg_spill_if.sv
// Memory port of the spill engine, grouped so master and memory model share one bundle.
interface reg_spill_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Handshake: mem_req acts as valid and mem_ack as ready. While mem_req is high,
  // mem_we/mem_addr/mem_wdata are held; the transfer completes on the rising edge
  // where mem_ack is sampled high, and mem_rdata is valid alongside that ack.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/pri_enc16.sv
// Lowest-set-bit priority encoder: 16-bit vector to 4-bit index plus valid flag.
module pri_enc16
  import reg_spill_pkg::*;
(
  input  logic [NREGS-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Walk downward so the last hit written is the lowest set bit.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_spill.sv
// Register spill/fill engine: saves masked registers to base+idx slots or restores them.
// Optional running XOR checksum of transferred words when REG_SPILL_CSUM_EN is defined.
module reg_spill
  import reg_spill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_save,
  input  logic              start_restore,
  input  logic [NREGS-1:0]  mask,
  input  logic [ADDR_W-1:0] base,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_selA,
  input  logic [DATA_W-1:0] rf_a,
  output logic              rf_wen,
  output logic [IDX_W-1:0]  rf_selR,
  output logic [DATA_W-1:0] rf_bus,
  reg_spill_if.master       mem,
  output logic [DATA_W-1:0] csum,
  output state_e            dbg_state
);

  state_e            state, state_n;
  logic [NREGS-1:0]  pending, pending_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic              save_q, save_n;
  logic [IDX_W-1:0]  sel_a_n, sel_r_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n, bus_n;
  logic              mem_req_q, mem_we_q;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic              start_any;

  assign start_any = start_save | start_restore;

  pri_enc16 u_enc (
    .vec   (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    idx_n     = idx;
    base_n    = base_q;
    save_n    = save_q;
    sel_a_n   = rf_selA;
    sel_r_n   = rf_selR;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    bus_n     = rf_bus;
    case (state)
      IDLE: begin
        if (start_any) begin
          pending_n = mask;
          base_n    = base;
          save_n    = start_save;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (!enc_valid) begin
          state_n = DONE;
        end else begin
          idx_n              = enc_idx;
          pending_n[enc_idx] = 1'b0;
          // Slots are fixed per register index, wrapping modulo the address space.
          addr_n             = base_q + ADDR_W'(enc_idx);
          if (save_q) begin
            sel_a_n = enc_idx;
            state_n = RD;
          end else begin
            state_n = MEM;
          end
        end
      end
      RD: begin
        wdata_n = rf_a;
        state_n = MEM;
      end
      MEM: begin
        if (mem.mem_ack) begin
          if (save_q) begin
            state_n = SCAN;
          end else begin
            bus_n   = mem.mem_rdata;
            sel_r_n = idx;
            state_n = WB;
          end
        end
      end
      WB:      state_n = SCAN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      idx       <= '0;
      base_q    <= '0;
      save_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rf_selA   <= '0;
      rf_wen    <= 1'b0;
      rf_selR   <= '0;
      rf_bus    <= '0;
    end else begin
      pending   <= pending_n;
      idx       <= idx_n;
      base_q    <= base_n;
      save_q    <= save_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      mem_req_q <= (state_n == MEM);
      mem_we_q  <= (state_n == MEM) && save_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      rf_selA   <= sel_a_n;
      rf_wen    <= (state_n == WB);
      rf_selR   <= sel_r_n;
      rf_bus    <= bus_n;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign dbg_state     = state;

`ifdef REG_SPILL_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (state == IDLE && start_any) begin
      csum_q <= '0;
    end else if (state == MEM && mem.mem_ack) begin
      csum_q <= csum_q ^ (save_q ? wdata_q : mem.mem_rdata);
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: doc/reg_spill.md
REG_SPILL -- requirements
Module: reg_spill

Interface
REQ-001 Parameter ADDR_W, default 16: memory address width.
REQ-002 Parameter DATA_W, default 16: register and memory word width; only 16 is supported.
REQ-003 Clock and reset SHALL be one clock and an asynchronous active-low reset, with ports named as the codebase does:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-004 Control ports SHALL be:
- start_save  in  1  begin a save (register file to memory).
- start_restore  in  1  begin a restore (memory to register file).
- mask  in  16  bit i selects register i; sampled at start.
- base  in  ADDR_W  slot base address; sampled at start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
REQ-005 Register-file port ports SHALL be:
- rf_selA  out  4  read select.
- rf_a  in  16  read data, combinational from rf_selA.
- rf_wen  out  1  write enable.
- rf_selR  out  4  write select.
- rf_bus  out  16  write data.
REQ-006 Memory port ports SHALL be:
- mem_req  out  1  request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with ack.
- mem_ack  in  1  completes the request.

Function
REQ-007 The FSM SHALL have the states IDLE, SCAN, RD, MEM, WB and DONE; all outputs SHALL be registered.
REQ-008 In IDLE, a start SHALL latch mask into pending, latch base, latch the direction, and go to SCAN. start_save SHALL win if both starts are high in the same cycle.
REQ-009 Start pulses SHALL be ignored while busy.
REQ-010 In SCAN: if pending==0, go to DONE; otherwise idx = lowest set bit of pending, clear that bit, and go to RD (save) or MEM (restore).
REQ-011 In RD: rf_selA = idx, and rf_a is captured into mem_wdata at the end of the cycle; then go to MEM.
REQ-012 In MEM: mem_req=1, mem_addr = base+idx (modulo 2^ADDR_W), mem_we = save. mem_req, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-013 On ack in MEM: a save goes to SCAN; a restore captures mem_rdata into rf_bus and goes to WB.
REQ-014 In WB: rf_wen=1 and rf_selR=idx for exactly one cycle; then go to SCAN.
REQ-015 mem_ack SHALL be ignored outside MEM.
REQ-016 In DONE: done=1 for one cycle; then go to IDLE.
REQ-017 Registers SHALL be processed in ascending index order. Slot addresses are fixed per index, not compacted.
REQ-018 Minimum per-register cost SHALL be 3 cycles for save (SCAN, RD, MEM with immediate ack) and 3 cycles for restore (SCAN, MEM, WB).
REQ-019 mask==0 SHALL give the sequence start, SCAN, DONE: done high 2 cycles after start is sampled, with no memory or register-file activity.
REQ-020 rf_wen SHALL never be high outside WB.
REQ-021 mem_req SHALL never be high outside MEM.

Reset
REQ-022 Asserting rst SHALL immediately force state=IDLE and clear all outputs, pending, idx and the latched base.
REQ-023 Reset mid-operation SHALL drop mem_req and rf_wen asynchronously and abandon the transfer; no done pulse is issued.
REQ-024 After release, the block SHALL accept a start on the first rising edge.

Configuration
REQ-025 Macro REG_SPILL_CSUM_EN defined: add output csum (16 bits), cleared at start. It is XORed with each word completed in MEM (save: mem_wdata; restore: mem_rdata) and is valid, and held, from DONE until the next start.
REQ-026 REG_SPILL_CSUM_EN undefined: csum SHALL be driven to 0 and hold no state.

Structure
REQ-027 The shared package or include SHALL hold: state encodings, NREGS=16, and the index width of 4.
REQ-028 One sub-module SHALL be used: pri_enc16 (combinational; 16-bit vector to 4-bit index of the lowest set bit plus a valid flag), used in SCAN.

Verification
REQ-029 Save: mask=16'h0005, base=16'h0100, r0=16'hAAAA, r2=16'h1234, immediate ack. Required: writes 0x0100<-AAAA then 0x0102<-1234, done 8 cycles after start.
REQ-030 Restore: mask=16'h8000, base=16'hFFF8, memory 0x0007=16'hBEEF. Required: address wraps to 0x0007; one rf_wen pulse with selR=15 and bus=BEEF; done follows.
REQ-031 Ack stall: mem_ack held low for 5 cycles during a save. Required: mem_req, mem_addr and mem_wdata stable throughout; the register following the stalled one starts only after ack.
REQ-032 mask=0 with start_save and start_restore high in the same cycle. Required: save direction latched, no mem_req, done 2 cycles after start; a start while busy has no effect.
REQ-033 rst asserted low mid-MEM. Required: mem_req drops within the same cycle, state=IDLE, no done; a new save after release completes correctly.
REQ-034 With REG_SPILL_CSUM_EN: save of r1=16'h00F0 and r3=16'h0F0F. Required: csum=16'h0FFF in DONE; without the macro, csum=0.
